// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory self-test sequencer: FSM states,
// pattern selectors and the data-pattern generator.
package mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAT_ADDR  = 2'd0,
        PAT_INV   = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SEED  = 2'd3
    } pat_e;

    // Computed at 32 bits; callers truncate to their data width.
    function automatic logic [31:0] pattern(input logic [31:0] addr,
                                            input pat_e        sel,
                                            input logic [31:0] seed);
        logic [31:0] result;
        case (sel)
            PAT_ADDR:  result = addr;
            PAT_INV:   result = ~addr;
            PAT_CHECK: result = addr[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            default:   result = seed;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_test_cmp_pipe.sv
// Read-latency matching pipeline: carries valid/expected/address tokens alongside
// the memory read, then compares at the tail and keeps a saturating error count.
module mem_test_cmp_pipe
    import mem_test_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              clr_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_exp_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [7:0]        err_cnt_o,
    output logic [ADDR_W-1:0] first_fail_o
);
    localparam int TAIL = READ_LATENCY - 1;

    logic              vld_q [READ_LATENCY];
    logic [DATA_W-1:0] exp_q [READ_LATENCY];
    logic [ADDR_W-1:0] adr_q [READ_LATENCY];
    logic              vld_in [READ_LATENCY];
    logic [DATA_W-1:0] exp_in [READ_LATENCY];
    logic [ADDR_W-1:0] adr_in [READ_LATENCY];
    logic [7:0]        err_cnt_q;
    logic [ADDR_W-1:0] first_fail_q;
    logic              mismatch;

    assign vld_in[0] = push_i;
    assign exp_in[0] = push_exp_i;
    assign adr_in[0] = push_addr_i;

    genvar gi;
    generate
        for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
            assign vld_in[gi] = vld_q[gi-1];
            assign exp_in[gi] = exp_q[gi-1];
            assign adr_in[gi] = adr_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (srst_i) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
                adr_q[i] <= '0;
            end else begin
                vld_q[i] <= flush_i ? 1'b0 : vld_in[i];
                exp_q[i] <= exp_in[i];
                adr_q[i] <= adr_in[i];
            end
        end
    end

    assign mismatch = vld_q[TAIL] && (rd_data_i != exp_q[TAIL]);

    // A saturated count never returns to zero, so zero also means "no failure yet".
    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            err_cnt_q    <= '0;
            first_fail_q <= '0;
        end else if (mismatch) begin
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            if (err_cnt_q == 8'h00) first_fail_q <= adr_q[TAIL];
        end
    end

    assign err_cnt_o    = err_cnt_q;
    assign first_fail_o = first_fail_q;
endmodule

// File: rtl/mem_test_sequencer.sv
// BIST sequencer for the BRAM path: writes a pattern to every address, reads it
// all back, and reports pass/fail, error count and first failing address.
module mem_test_sequencer
    import mem_test_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_mem,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] seed,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        error_count,
    output logic [ADDR_W-1:0] first_fail_addr
);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        drain_q, drain_d;
    pat_e              sel_q, sel_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              pass_q, pass_d;
    logic              clr, flush, push;
    logic [DATA_W-1:0] cur_pattern;

    assign cur_pattern = DATA_W'(pattern(32'(addr_q), sel_q, 32'(seed_q)));

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            sel_q   <= PAT_ADDR;
            seed_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            sel_q   <= sel_d;
            seed_q  <= seed_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        sel_d   = sel_q;
        seed_d  = seed_q;
        pass_d  = pass_q;
        clr     = 1'b0;
        flush   = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    sel_d   = pat_e'(pattern_sel);
                    seed_d  = seed;
                    pass_d  = 1'b0;
                    clr     = 1'b1;
                end
            end
            WRITE: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = READ;
            end
            READ: begin
                push   = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                pass_d  = (error_count == 8'h00);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort drops in-flight compare tokens so the reported counts freeze.
        if (abort && busy) begin
            state_d = IDLE;
            flush   = 1'b1;
            push    = 1'b0;
        end
    end

    assign mem_write_enable = (state_q == WRITE);
    assign mem_read_enable  = (state_q == READ);
    assign mem_address      = (mem_write_enable || mem_read_enable) ? addr_q : '0;
    assign mem_write_data   = mem_write_enable ? cur_pattern : '0;
    assign busy             = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;

    mem_test_cmp_pipe #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_cmp_pipe (
        .clk_i        (clk_mem),
        .srst_i       (reset),
        .clr_i        (clr),
        .flush_i      (flush),
        .push_i       (push),
        .push_exp_i   (cur_pattern),
        .push_addr_i  (addr_q),
        .rd_data_i    (mem_read_data),
        .err_cnt_o    (error_count),
        .first_fail_o (first_fail_addr)
    );
endmodule

// File: tb/tb_mem_test_sequencer.sv
// Self-checking bench: BRAM model with injectable read faults plus a reference
// that derives expected results directly from the pattern and fault rules.
module tb_mem_test_sequencer;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int L  = 1;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [1:0]    pattern_sel;
    logic [DW-1:0] seed;
    logic          mem_write_enable, mem_read_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          busy, done, pass;
    logic [7:0]    error_count;
    logic [AW-1:0] first_fail_addr;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_pipe [L];

    always #5 clk = ~clk;

    mem_test_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(L)) dut (
        .clk_mem          (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .pattern_sel      (pattern_sel),
        .seed             (seed),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .error_count      (error_count),
        .first_fail_addr  (first_fail_addr)
    );

    function automatic logic [DW-1:0] apply_fault(input int a, input logic [DW-1:0] d);
        case (fault_mode)
            1:       return (a == 16) ? 8'h00 : d;
            2:       return d & 8'hFE;
            3:       return 8'hFF;
            default: return d;
        endcase
    endfunction

    function automatic logic [DW-1:0] spec_pat(input int a, input int sel, input logic [DW-1:0] sd);
        case (sel)
            0:       return 8'(a);
            1:       return 8'(255 - a);
            2:       return (a % 2 == 0) ? 8'h55 : 8'hAA;
            default: return sd;
        endcase
    endfunction

    // BRAM model: data appears L cycles after the read address is sampled.
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        if (mem_read_enable) rd_pipe[0] <= apply_fault(int'(mem_address), mem[mem_address]);
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_read_data = rd_pipe[L-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {27'd0, mem_write_enable, mem_read_enable, busy, done, pass}, 32'd0);
        check_val({tag, "_bus"}, {16'd0, mem_address, mem_write_data}, 32'd0);
        check_val({tag, "_res"}, {16'd0, error_count, first_fail_addr}, 32'd0);
    endtask

    task automatic run_test(input int sel, input logic [DW-1:0] sd, input int fm, input int mid_start);
        int exp_err = 0;
        int exp_first = 0;
        int wr_bad = 0;
        int both_bad = 0;
        int reads = 0;
        int done_cyc = 0;
        logic [DW-1:0] p;
        fault_mode = fm;
        for (int a = 0; a < N; a++) begin
            p = spec_pat(a, sel, sd);
            if (apply_fault(a, p) != p) begin
                if (exp_err == 0) exp_first = a;
                if (exp_err < 255) exp_err++;
            end
        end
        pattern_sel = 2'(sel);
        seed        = sd;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 2000; n++) begin
            if (mem_write_enable && mem_write_data != spec_pat(int'(mem_address), sel, sd)) wr_bad++;
            if (mem_write_enable && mem_read_enable) both_bad++;
            if (mem_read_enable) reads++;
            if (done) begin
                done_cyc = n;
                break;
            end
            if (n == mid_start) begin
                start       = 1'b1;
                pattern_sel = ~pattern_sel;
                seed        = ~seed;
            end
            tick();
            start = 1'b0;
        end
        check_val("done_cycle", done_cyc, 2 * N + L + 1);
        check_val("error_count", {24'd0, error_count}, exp_err);
        check_val("first_fail", {24'd0, first_fail_addr}, exp_first);
        check_val("write_data", wr_bad, 0);
        check_val("read_count", reads, N);
        check_val("strobe_excl", both_bad, 0);
        tick();
        check_val("pass", {31'd0, pass}, {31'd0, exp_err == 0});
        check_val("idle_after", {31'd0, busy}, 0);
        $display("run sel=%0d seed=%02h fault=%0d done@%0d err=%0d first=%02h pass=%0b",
                 sel, sd, fm, done_cyc, error_count, first_fail_addr, pass);
    endtask

    task automatic run_abort(input int sel, input int fm, input int abort_cyc);
        logic [7:0] ec;
        int dones = 0;
        fault_mode  = fm;
        pattern_sel = 2'(sel);
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < abort_cyc; n++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_strobes", {30'd0, mem_write_enable, mem_read_enable}, 0);
        check_val("abort_busy", {31'd0, busy}, 0);
        ec = error_count;
        for (int n = 0; n < 600; n++) begin
            if (done) dones++;
            tick();
        end
        check_val("abort_no_done", dones, 0);
        check_val("abort_freeze", {24'd0, error_count}, {24'd0, ec});
        check_val("abort_pass", {31'd0, pass}, 0);
        $display("abort sel=%0d fault=%0d at cycle %0d err_frozen=%0d dones=%0d", sel, fm, abort_cyc, ec, dones);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; pattern_sel = 2'd0; seed = '0;
        tick(); tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("post_reset");
        $display("reset all outputs checked");

        run_test(0, 8'h00, 0, 0);
        run_test(0, 8'h00, 1, 0);
        run_test(2, 8'h00, 2, 0);
        run_test(3, 8'h00, 3, 0);

        run_abort(2, 2, 300);
        run_test(0, 8'h00, 0, 0);

        run_test(1, 8'h3C, 0, 50);

        // Reset pulsed mid-test.
        fault_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 100; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid_reset");
        for (int n = 0; n < 20; n++) tick();
        check_val("mid_reset_idle", {31'd0, busy}, 0);
        $display("reset at cycle 100 checked");

        // Abort wins over start in IDLE.
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        tick();
        check_val("abort_start_idle", {30'd0, busy, mem_write_enable}, 0);
        $display("abort+start in idle checked busy=%0b", busy);

        for (int r = 0; r < 4; r++)
            run_test($urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_test_sequencer.md
Name: mem_test_sequencer

Overview:
- Built-in self-test sequencer that sits directly upstream of memory_controller in the clk_mem domain.
- Drives memory_controller's write_enable, write_data, read_address and read_enable ports and consumes its read_data.
- Sequence: write a selectable pattern to every address, read every address back, compare each result against the expected pattern, then report pass/fail, error count and first failing address.
- Used for board bring-up and regression of the BRAM path.

Parameters:
- ADDR_W, 8, address width; the test covers 2**ADDR_W locations.
- DATA_W, 8, data width.
- READ_LATENCY, 1, clk_mem cycles from address issue to valid mem_read_data (legal range 1..4).

Ports:
- clk_mem  input  1  memory clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a test; sampled only in IDLE.
- abort  input  1  stops the test and returns to IDLE without asserting done.
- pattern_sel  input  2  0=address, 1=~address, 2=checkerboard (0x55 at even addr, 0xAA at odd), 3=seed constant.
- seed  input  DATA_W  constant used when pattern_sel=3.
- mem_write_enable  output  1  to memory_controller write_enable.
- mem_read_enable  output  1  to memory_controller read_enable.
- mem_address  output  ADDR_W  to memory_controller read_address; shared by writes and reads.
- mem_write_data  output  DATA_W  to memory_controller write_data.
- mem_read_data  input  DATA_W  from memory_controller read_data.
- busy  output  1  high in WRITE, READ and DRAIN.
- done  output  1  one-cycle pulse when a test completes.
- pass  output  1  valid after done; high iff error_count==0; held until the next start.
- error_count  output  8  number of mismatches; saturates at 255.
- first_fail_addr  output  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset: all outputs are 0. State=IDLE, counters=0, compare pipeline cleared.
- pattern_sel and seed are latched at start and held for the whole test.
- States and transitions:
  - IDLE: start=1 -> WRITE; error_count, first_fail_addr and pass are cleared. done=0.
  - WRITE: mem_write_enable=1, mem_address=addr_cnt, mem_write_data=pattern(addr_cnt); one write per cycle. At addr_cnt=2**ADDR_W-1 -> READ, addr_cnt wraps to 0.
  - READ: mem_write_enable=0, mem_read_enable=1, mem_address=addr_cnt; one read per cycle. A valid/expected/address token is pushed into a READ_LATENCY-deep shift pipeline. At the last address -> DRAIN.
  - DRAIN: no memory strobes; waits READ_LATENCY cycles for the pipeline to empty, then -> DONE.
  - DONE: done=1 for one cycle; pass=(error_count==0); -> IDLE.
- Cycle timing with start sampled in IDLE at cycle 0:
  - writes occupy cycles 1..2**ADDR_W;
  - reads occupy the next 2**ADDR_W cycles;
  - done occurs at cycle 2*2**ADDR_W+READ_LATENCY+1.
- Compare: when the pipeline tail is valid, mem_read_data is compared with the expected value.
  - On mismatch, error_count increments, saturating at 255.
  - first_fail_addr is captured only on the first mismatch.
- start while busy is ignored.
- abort=1 in any busy state -> IDLE on the next edge. Memory strobes drop that edge, no done pulse, pass stays 0, counts freeze.
- abort and start together in IDLE: abort wins and start is ignored.
- reset mid-test: returns to the reset state on the next edge regardless of other inputs.
- Only one of mem_write_enable and mem_read_enable is ever high in a cycle.

Decomposition:
- Shared package mem_test_pkg holds:
  - state encoding constants (IDLE, WRITE, READ, DRAIN, DONE);
  - PAT_ADDR, PAT_INV, PAT_CHECK, PAT_SEED;
  - the pattern function pattern(addr, sel, seed).
- One natural sub-module, mem_test_cmp_pipe: the READ_LATENCY-deep valid/expected/address shift register plus the compare and saturating error counter.

Test Plan:
- Ideal BRAM model, pattern_sel=0, start pulse -> writes 0x00..0xFF at addresses 0..255; done at cycle 514 (L=1); pass=1; error_count=0.
- Model corrupts the read at address 0x10 (returns 0x00 instead of 0x10) -> error_count=1, first_fail_addr=0x10, pass=0.
- Model stuck-at-0 on bit 0 with pattern_sel=2 -> 128 mismatches (odd addresses, 0xAA reads fine; even 0x55 reads 0x54); error_count=128, first_fail_addr=0x00.
- Model returns 0xFF everywhere, pattern_sel=3, seed=0x00 -> error_count saturates at 255; pass=0.
- abort asserted at cycle 300 (READ phase) -> strobes low at the next edge, busy=0, no done pulse; a new start then runs to pass=1.
- reset pulsed at cycle 100, and start pulsed while busy -> all outputs 0 after reset; the mid-test start has no effect on the cycle count of the running test.
